// File: rtl/cpu_control_unit_if.sv
// Control-side bundle between the Simple CPU sequencer and its datapath/memory.
// master = control unit (drives strobes), slave = datapath + memory (drives ir, z, mem_ready).
interface cpu_control_unit_if;
  logic [7:0] ir;
  logic       z;
  logic       mem_ready;
  logic [3:0] alusel;
  logic [2:0] bus_sel;
  logic       ar_ld;
  logic       dr_ld;
  logic       ir_ld;
  logic       ac_ld;
  logic       pc_ld;
  logic       pc_inc;
  logic       mem_rd;
  logic       mem_wr;
  logic       instr_done;
  logic       halt;
  logic       err;

  modport master (
    input  ir, z, mem_ready,
    output alusel, bus_sel, ar_ld, dr_ld, ir_ld, ac_ld, pc_ld, pc_inc,
           mem_rd, mem_wr, instr_done, halt, err
  );

  modport slave (
    output ir, z, mem_ready,
    input  alusel, bus_sel, ar_ld, dr_ld, ir_ld, ac_ld, pc_ld, pc_inc,
           mem_rd, mem_wr, instr_done, halt, err
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer for the 8-bit Simple CPU: fetch opcode (+ operand),
// then drive ALU select, bus source and register strobes; halts on HALT or memory timeout.
module cpu_control_unit #(
  parameter int TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  cpu_control_unit_if.master ctrl
);

  typedef enum logic [3:0] {
    st_f1, st_f2, st_f3, st_dec, st_o1, st_o2, st_o3, st_m1, st_l2, st_hlt
  } state_t;

  localparam logic [3:0] op_ldac = 4'h1;
  localparam logic [3:0] op_stac = 4'h2;
  localparam logic [3:0] op_add  = 4'h3;
  localparam logic [3:0] op_sub  = 4'h4;
  localparam logic [3:0] op_inac = 4'h5;
  localparam logic [3:0] op_clac = 4'h6;
  localparam logic [3:0] op_and  = 4'h7;
  localparam logic [3:0] op_or   = 4'h8;
  localparam logic [3:0] op_xor  = 4'h9;
  localparam logic [3:0] op_not  = 4'hA;
  localparam logic [3:0] op_jump = 4'hB;
  localparam logic [3:0] op_jmpz = 4'hC;
  localparam logic [3:0] op_halt = 4'hF;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, next;
  logic [CW-1:0] cnt;
  logic          errq;
  logic          waiting;
  logic          expired;
  logic          timeout;
  logic [3:0]    op;

  assign op      = ctrl.ir[7:4];
  assign waiting = (state == st_f2) || (state == st_o2) || (state == st_m1);
  assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // The wait counter restarts whenever we are outside a wait state, so every wait begins at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_f1;
      cnt   <= '0;
      errq  <= 1'b0;
    end else begin
      state <= next;
      if (waiting && !ctrl.mem_ready) cnt <= cnt + 1'b1;
      else                            cnt <= '0;
      if (timeout) errq <= 1'b1;
    end
  end

  always_comb begin
    next            = state;
    timeout         = 1'b0;
    ctrl.alusel     = 4'd0;
    ctrl.bus_sel    = 3'd0;
    ctrl.ar_ld      = 1'b0;
    ctrl.dr_ld      = 1'b0;
    ctrl.ir_ld      = 1'b0;
    ctrl.ac_ld      = 1'b0;
    ctrl.pc_ld      = 1'b0;
    ctrl.pc_inc     = 1'b0;
    ctrl.mem_rd     = 1'b0;
    ctrl.mem_wr     = 1'b0;
    ctrl.instr_done = 1'b0;
    ctrl.halt       = 1'b0;
    ctrl.err        = 1'b0;
    if (rst) begin
      next = st_f1;
    end else begin
      ctrl.err = errq;
      case (state)
        st_f1, st_o1: begin
          ctrl.bus_sel = 3'd1;
          ctrl.ar_ld   = 1'b1;
          next         = (state == st_f1) ? st_f2 : st_o2;
        end
        st_f2, st_o2: begin
          ctrl.mem_rd  = 1'b1;
          ctrl.bus_sel = 3'd4;
          if (ctrl.mem_ready) begin
            ctrl.dr_ld  = 1'b1;
            ctrl.pc_inc = 1'b1;
            next        = (state == st_f2) ? st_f3 : st_o3;
          end else if (expired) begin
            timeout = 1'b1;
            next    = st_hlt;
          end
        end
        st_f3: begin
          ctrl.bus_sel = 3'd2;
          ctrl.ir_ld   = 1'b1;
          next         = st_dec;
        end
        st_dec: begin
          case (op)
            op_inac, op_clac, op_not: begin
              ctrl.ac_ld      = 1'b1;
              ctrl.instr_done = 1'b1;
              next            = st_f1;
              if (op == op_inac)      ctrl.alusel = 4'd3;
              else if (op == op_clac) ctrl.alusel = 4'd4;
              else                    ctrl.alusel = 4'd8;
            end
            op_ldac, op_stac, op_add, op_sub, op_and, op_or, op_xor, op_jump, op_jmpz:
              next = st_o1;
            op_halt: next = st_hlt;
            default: begin
              ctrl.instr_done = 1'b1;
              next            = st_f1;
            end
          endcase
        end
        st_o3: begin
          ctrl.instr_done = 1'b1;
          next            = st_f1;
          case (op)
            op_add, op_sub, op_and, op_or, op_xor: begin
              ctrl.bus_sel = 3'd2;
              ctrl.ac_ld   = 1'b1;
              case (op)
                op_add:  ctrl.alusel = 4'd1;
                op_sub:  ctrl.alusel = 4'd2;
                op_and:  ctrl.alusel = 4'd5;
                op_or:   ctrl.alusel = 4'd6;
                default: ctrl.alusel = 4'd7;
              endcase
            end
            op_jump: begin
              ctrl.bus_sel = 3'd2;
              ctrl.pc_ld   = 1'b1;
            end
            op_jmpz: begin
              if (ctrl.z) begin
                ctrl.bus_sel = 3'd2;
                ctrl.pc_ld   = 1'b1;
              end
            end
            op_ldac, op_stac: begin
              ctrl.bus_sel    = 3'd2;
              ctrl.ar_ld      = 1'b1;
              ctrl.instr_done = 1'b0;
              next            = st_m1;
            end
            default: ;
          endcase
        end
        // STAC finishes straight from the write; LDAC still has to move DR into AC.
        st_m1: begin
          if (op == op_stac) begin
            ctrl.mem_wr  = 1'b1;
            ctrl.bus_sel = 3'd3;
            if (ctrl.mem_ready) begin
              ctrl.instr_done = 1'b1;
              next            = st_f1;
            end
          end else begin
            ctrl.mem_rd  = 1'b1;
            ctrl.bus_sel = 3'd4;
            if (ctrl.mem_ready) begin
              ctrl.dr_ld = 1'b1;
              next       = st_l2;
            end
          end
          if (!ctrl.mem_ready && expired) begin
            timeout = 1'b1;
            next    = st_hlt;
          end
        end
        st_l2: begin
          ctrl.bus_sel    = 3'd2;
          ctrl.alusel     = 4'd0;
          ctrl.ac_ld      = 1'b1;
          ctrl.instr_done = 1'b1;
          next            = st_f1;
        end
        st_hlt: ctrl.halt = 1'b1;
        default: next = st_f1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: each stimulus cycle pushes its expected output word,
// and a negedge monitor pops and compares the word for the current cycle.
module tb_cpu_control_unit;

  typedef struct {
    int unsigned cyc;
    logic [17:0] exp;
    string       name;
  } sb_t;

  localparam logic [10:0] f_none  = 11'h000;
  localparam logic [10:0] f_ar    = 11'h400;
  localparam logic [10:0] f_dr    = 11'h200;
  localparam logic [10:0] f_ir    = 11'h100;
  localparam logic [10:0] f_ac    = 11'h080;
  localparam logic [10:0] f_pcld  = 11'h040;
  localparam logic [10:0] f_pcinc = 11'h020;
  localparam logic [10:0] f_rd    = 11'h010;
  localparam logic [10:0] f_wr    = 11'h008;
  localparam logic [10:0] f_done  = 11'h004;
  localparam logic [10:0] f_halt  = 11'h002;
  localparam logic [10:0] f_err   = 11'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  sb_t         sbq[$];
  logic [17:0] obs;

  cpu_control_unit_if ifc ();

  cpu_control_unit #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {ifc.alusel, ifc.bus_sel, ifc.ar_ld, ifc.dr_ld, ifc.ir_ld, ifc.ac_ld,
                ifc.pc_ld, ifc.pc_inc, ifc.mem_rd, ifc.mem_wr, ifc.instr_done,
                ifc.halt, ifc.err};

  function automatic logic [17:0] mk(input logic [3:0] a, input logic [2:0] b,
                                     input logic [10:0] f);
    return {a, b, f};
  endfunction

  task automatic checkOutput(input sb_t e);
    compared++;
    if (obs !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s cyc=%0d got=%05h expected=%05h", e.name, e.cyc, obs, e.exp);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) checkOutput(sbq.pop_front());
  end

  task automatic applyStimulus(input logic r, input logic [7:0] i, input logic zz,
                               input logic rdy, input logic [17:0] e, input string nm);
    sb_t s;
    @(posedge clk);
    #1;
    rst           = r;
    ifc.ir        = i;
    ifc.z         = zz;
    ifc.mem_ready = rdy;
    s.cyc  = cyc;
    s.exp  = e;
    s.name = nm;
    sbq.push_back(s);
  endtask

  task automatic doFetch(input logic [7:0] i, input logic zz, input int waits, input string nm);
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd1, f_ar), {nm, ":f1"});
    for (int k = 0; k < waits; k++)
      applyStimulus(1'b0, i, zz, 1'b0, mk(4'd0, 3'd4, f_rd), {nm, ":f2wait"});
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd4, f_rd | f_dr | f_pcinc), {nm, ":f2"});
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd2, f_ir), {nm, ":f3"});
  endtask

  task automatic doOperand(input logic [7:0] i, input logic zz, input string nm);
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd0, f_none), {nm, ":dec"});
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd1, f_ar), {nm, ":o1"});
    applyStimulus(1'b0, i, zz, 1'b1, mk(4'd0, 3'd4, f_rd | f_dr | f_pcinc), {nm, ":o2"});
  endtask

  task automatic doAluImm(input logic [7:0] i, input logic [3:0] sel, input int waits,
                          input string nm);
    doFetch(i, 1'b0, waits, nm);
    doOperand(i, 1'b0, nm);
    applyStimulus(1'b0, i, 1'b0, 1'b1, mk(sel, 3'd2, f_ac | f_done), {nm, ":o3"});
  endtask

  task automatic doOneByte(input logic [7:0] i, input logic [3:0] sel, input logic [10:0] f,
                           input string nm);
    doFetch(i, 1'b0, 0, nm);
    applyStimulus(1'b0, i, 1'b0, 1'b1, mk(sel, 3'd0, f), {nm, ":dec"});
  endtask

  initial begin
    ifc.ir        = 8'hF0;
    ifc.z         = 1'b0;
    ifc.mem_ready = 1'b1;

    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "reset0");
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "reset1");

    doOneByte(8'h00, 4'd0, f_done, "nop");
    doAluImm(8'h35, 4'd1, 0, "add");
    doAluImm(8'h40, 4'd2, 0, "sub");
    doAluImm(8'h70, 4'd5, 0, "and");
    doAluImm(8'h80, 4'd6, 2, "or");
    doAluImm(8'h9F, 4'd7, 0, "xor");
    doOneByte(8'h50, 4'd3, f_ac | f_done, "inac");
    doOneByte(8'h60, 4'd4, f_ac | f_done, "clac");
    doOneByte(8'hA0, 4'd8, f_ac | f_done, "not");
    doOneByte(8'hD0, 4'd0, f_done, "opd");

    // LDAC with three stalled cycles in M1; ready lands on the last count before timeout
    doFetch(8'h10, 1'b0, 0, "ldac");
    doOperand(8'h10, 1'b0, "ldac");
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b1, mk(4'd0, 3'd2, f_ar), "ldac:o3");
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 8'h10, 1'b0, 1'b0, mk(4'd0, 3'd4, f_rd), "ldac:m1wait");
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b1, mk(4'd0, 3'd4, f_rd | f_dr), "ldac:m1");
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b1, mk(4'd0, 3'd2, f_ac | f_done), "ldac:l2");

    doFetch(8'h20, 1'b0, 0, "stac");
    doOperand(8'h20, 1'b0, "stac");
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b1, mk(4'd0, 3'd2, f_ar), "stac:o3");
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b1, mk(4'd0, 3'd3, f_wr | f_done), "stac:m1");

    doFetch(8'hB0, 1'b0, 0, "jump");
    doOperand(8'hB0, 1'b0, "jump");
    applyStimulus(1'b0, 8'hB0, 1'b0, 1'b1, mk(4'd0, 3'd2, f_pcld | f_done), "jump:o3");

    doFetch(8'hC0, 1'b0, 0, "jmpz0");
    doOperand(8'hC0, 1'b0, "jmpz0");
    applyStimulus(1'b0, 8'hC0, 1'b0, 1'b1, mk(4'd0, 3'd0, f_done), "jmpz0:o3");

    doFetch(8'hC0, 1'b1, 0, "jmpz1");
    doOperand(8'hC0, 1'b1, "jmpz1");
    applyStimulus(1'b0, 8'hC0, 1'b1, 1'b1, mk(4'd0, 3'd2, f_pcld | f_done), "jmpz1:o3");

    // reset in O2 aborts the instruction with no strobes, fetch restarts cleanly
    doFetch(8'h30, 1'b0, 0, "abort");
    applyStimulus(1'b0, 8'h30, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "abort:dec");
    applyStimulus(1'b0, 8'h30, 1'b0, 1'b1, mk(4'd0, 3'd1, f_ar), "abort:o1");
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "abort:o2rst");
    doOneByte(8'h00, 4'd0, f_done, "afterabort");

    doFetch(8'hF0, 1'b0, 0, "halt");
    applyStimulus(1'b0, 8'hF0, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "halt:dec");
    for (int k = 0; k < 100; k++)
      applyStimulus(1'b0, 8'hF0, 1'b0, k[0], mk(4'd0, 3'd0, f_halt), "halt:hold");
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "halt:rst");

    // memory never answers in F2: four wait cycles then halt with err
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, mk(4'd0, 3'd1, f_ar), "tmo:f1");
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, mk(4'd0, 3'd4, f_rd), "tmo:f2wait");
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, mk(4'd0, 3'd0, f_halt | f_err), "tmo:hlt");
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, mk(4'd0, 3'd0, f_none), "tmo:rst");
    doOneByte(8'h00, 4'd0, f_done, "aftertmo");

    repeat (2) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain left=%0d required=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
